des_iter_ctrl: RTL
==================

// Module: des_iter_ctrl
// PURPOSE
//  Iterative DES engine controller: accepts one 64-bit block + 64-bit key via valid/ready,
//  sequences the existing IP, round (f-function, E, S-boxes, P), PC1/PC2 and FP logic over
//  16 rounds, and returns the result via valid/ready. Replaces the 16x unrolled datapath.
//  The key schedule is computed on the fly from C/D registers. No round-key array is stored.
//  Sits between a bus-side request block and consumers of ciphertext/plaintext.
// PARAMETERS
//  RPC  1  rounds per clock; legal values 1,2,4,8,16; compute cycles NR = 16/RPC
// PORTS
//  clk         in   1   clock, all flops on posedge
//  rst         in   1   synchronous, active-high reset
//  in_valid    in   1   request valid
//  in_ready    out  1   controller can accept a request
//  in_decrypt  in   1   0=encrypt, 1=decrypt; sampled on accept
//  in_text     in   64  plaintext/ciphertext block, bit 63 = DES bit 1
//  in_key      in   64  key incl. parity bits; parity ignored
//  out_valid   out  1   result valid
//  out_ready   in   1   consumer accepts result
//  out_text    out  64  result block
//  busy        out  1   FSM not IDLE
//  round_idx   out  4   rounds completed minus 1 during RUN; 0 otherwise
//  abort       in   1   present only with DES_ABORT_EN, see CONFIGURATION
// BEHAVIOUR
//  Reset: FSM=IDLE, in_ready=1, out_valid=0, out_text=0, busy=0, round_idx=0, L/R/C/D=0.
//  FSM states: IDLE -> RUN -> DONE -> IDLE.
//   IDLE: in_ready=1. On in_valid&in_ready:
//    - load {L,R}=IP(in_text) and {C,D}=PC1(in_key)
//    - latch mode and clear cnt
//    - go to RUN
//   RUN: in_ready=0. Each cycle applies RPC rounds, then cnt += RPC.
//    Each round computes L'=R and R'=L^f(R,K), with K=PC2(C,D) after that round's shift.
//    - Encrypt: rotate C,D left by 1 in rounds 1,2,9,16 and by 2 in all other rounds,
//      before PC2.
//    - Decrypt: round 1 uses unshifted C,D. Then rotate right by 1 before rounds 2,9,16
//      and by 2 before all other rounds.
//    - After the round-16 cycle, out_text=FP({R,L}) (halves swapped) is registered.
//      out_valid=1 and the FSM goes to DONE.
//   DONE: out_valid=1 and out_text hold stable until out_valid&out_ready, then go to IDLE.
//    in_ready stays 0 in DONE. There is no same-cycle re-accept.
//  Latency: with acceptance in cycle T, out_valid rises in cycle T+NR (RPC=1: T+16).
//   Throughput is one block per NR+2 cycles when out_ready is held high.
//  round_idx = cnt-1 in RUN, clamped to 0..15.
//  Boundaries:
//   - in_valid while busy: ignored, not queued. The requester must hold it until in_ready.
//   - in_text/in_key/in_decrypt changes after accept: no effect on the block in flight.
//   - out_ready low: indefinite stall in DONE with no data change.
//   - out_ready high already when out_valid rises: handshake completes that same cycle.
//   - rst in any state: next cycle is the reset state. The in-flight block is discarded
//     and no out_valid is issued.
//   - rst together with in_valid: rst wins and nothing is accepted.
//   - Weak/semi-weak keys and all-zero inputs: no special handling.
// CONFIGURATION
//  DES_ABORT_EN defined: adds the abort input.
//   - abort=1 in RUN: next cycle is IDLE, out_valid stays 0, and L/R/C/D are zeroed.
//   - abort=1 in DONE: drops the result, out_valid=0 next cycle.
//   - abort=1 in IDLE: ignored, and a simultaneous in_valid is not accepted.
//   - abort has lower priority than rst.
//  DES_ABORT_EN undefined: no abort port, and the FSM has no abort paths.
// TESTING
//  1. Encrypt key=133457799BBCDFF1, text=0123456789ABCDEF, out_ready=1
//     -> out_text=85E813540F0AB405 exactly 16 cycles after accept (RPC=1).
//  2. Decrypt key=133457799BBCDFF1, text=85E813540F0AB405 -> out_text=0123456789ABCDEF.
//  3. Encrypt key=0000000000000000, text=0000000000000000 -> 8CA64DE9C1B123A7.
//     Repeat with key=0101010101010101 -> identical result (parity ignored).
//  4. Hold out_ready=0 for 20 cycles after out_valid -> out_text stable, in_ready=0.
//     A new in_valid with a different block is not accepted.
//     Release out_ready -> in_ready=1 one cycle later.
//  5. Assert rst at round 7 of test 1 -> all outputs at reset values next cycle, and no
//     out_valid. A fresh request then completes with correct output.
//  6. RPC=4 build: test 1 vector -> same ciphertext, out_valid 4 cycles after accept.
//     With DES_ABORT_EN, abort at round_idx=3 -> IDLE, no out_valid.

Source files
------------

// File: rtl/des_iter_ctrl_if.sv
// Request/response bundle for the iterative DES controller.
// master = requester/consumer side, slave = the controller.
interface des_iter_ctrl_if;
    logic        in_valid;
    logic        in_ready;
    logic        in_decrypt;
    logic [63:0] in_text;
    logic [63:0] in_key;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_text;
    logic        busy;
    logic [3:0]  round_idx;

    modport master (
        output in_valid, in_decrypt, in_text, in_key, out_ready,
        input  in_ready, out_valid, out_text, busy, round_idx
    );

    modport slave (
        input  in_valid, in_decrypt, in_text, in_key, out_ready,
        output in_ready, out_valid, out_text, busy, round_idx
    );
endinterface

// File: rtl/des_iter_ctrl.sv
// Iterative DES controller, RPC rounds per clock, key schedule rolled from C/D.
// Define DES_ABORT_EN to add the abort input and its FSM paths.
module des_iter_ctrl #(
    parameter int RPC = 1
) (
    input  logic clk,
    input  logic rst,
`ifdef DES_ABORT_EN
    input  logic abort,
`endif
    des_iter_ctrl_if.slave io
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    localparam logic [6:0] IP_T [64] = '{
        58, 50, 42, 34, 26, 18, 10, 2, 60, 52, 44, 36, 28, 20, 12, 4,
        62, 54, 46, 38, 30, 22, 14, 6, 64, 56, 48, 40, 32, 24, 16, 8,
        57, 49, 41, 33, 25, 17, 9,  1, 59, 51, 43, 35, 27, 19, 11, 3,
        61, 53, 45, 37, 29, 21, 13, 5, 63, 55, 47, 39, 31, 23, 15, 7
    };

    localparam logic [6:0] FP_T [64] = '{
        40, 8, 48, 16, 56, 24, 64, 32, 39, 7, 47, 15, 55, 23, 63, 31,
        38, 6, 46, 14, 54, 22, 62, 30, 37, 5, 45, 13, 53, 21, 61, 29,
        36, 4, 44, 12, 52, 20, 60, 28, 35, 3, 43, 11, 51, 19, 59, 27,
        34, 2, 42, 10, 50, 18, 58, 26, 33, 1, 41, 9,  49, 17, 57, 25
    };

    localparam logic [5:0] E_T [48] = '{
        32, 1,  2,  3,  4,  5,  4,  5,  6,  7,  8,  9,
        8,  9,  10, 11, 12, 13, 12, 13, 14, 15, 16, 17,
        16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25,
        24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32, 1
    };

    localparam logic [5:0] P_T [32] = '{
        16, 7,  20, 21, 29, 12, 28, 17, 1,  15, 23, 26, 5,  18, 31, 10,
        2,  8,  24, 14, 32, 27, 3,  9,  19, 13, 30, 6,  22, 11, 4,  25
    };

    localparam logic [6:0] PC1_T [56] = '{
        57, 49, 41, 33, 25, 17, 9,  1,  58, 50, 42, 34, 26, 18,
        10, 2,  59, 51, 43, 35, 27, 19, 11, 3,  60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15, 7,  62, 54, 46, 38, 30, 22,
        14, 6,  61, 53, 45, 37, 29, 21, 13, 5,  28, 20, 12, 4
    };

    localparam logic [5:0] PC2_T [48] = '{
        14, 17, 11, 24, 1,  5,  3,  28, 15, 6,  21, 10,
        23, 19, 12, 4,  26, 8,  16, 7,  27, 20, 13, 2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };

    localparam logic [3:0] SBOX [8][64] = '{
        '{14, 4, 13, 1, 2, 15, 11, 8, 3, 10, 6, 12, 5, 9, 0, 7,
          0, 15, 7, 4, 14, 2, 13, 1, 10, 6, 12, 11, 9, 5, 3, 8,
          4, 1, 14, 8, 13, 6, 2, 11, 15, 12, 9, 7, 3, 10, 5, 0,
          15, 12, 8, 2, 4, 9, 1, 7, 5, 11, 3, 14, 10, 0, 6, 13},
        '{15, 1, 8, 14, 6, 11, 3, 4, 9, 7, 2, 13, 12, 0, 5, 10,
          3, 13, 4, 7, 15, 2, 8, 14, 12, 0, 1, 10, 6, 9, 11, 5,
          0, 14, 7, 11, 10, 4, 13, 1, 5, 8, 12, 6, 9, 3, 2, 15,
          13, 8, 10, 1, 3, 15, 4, 2, 11, 6, 7, 12, 0, 5, 14, 9},
        '{10, 0, 9, 14, 6, 3, 15, 5, 1, 13, 12, 7, 11, 4, 2, 8,
          13, 7, 0, 9, 3, 4, 6, 10, 2, 8, 5, 14, 12, 11, 15, 1,
          13, 6, 4, 9, 8, 15, 3, 0, 11, 1, 2, 12, 5, 10, 14, 7,
          1, 10, 13, 0, 6, 9, 8, 7, 4, 15, 14, 3, 11, 5, 2, 12},
        '{7, 13, 14, 3, 0, 6, 9, 10, 1, 2, 8, 5, 11, 12, 4, 15,
          13, 8, 11, 5, 6, 15, 0, 3, 4, 7, 2, 12, 1, 10, 14, 9,
          10, 6, 9, 0, 12, 11, 7, 13, 15, 1, 3, 14, 5, 2, 8, 4,
          3, 15, 0, 6, 10, 1, 13, 8, 9, 4, 5, 11, 12, 7, 2, 14},
        '{2, 12, 4, 1, 7, 10, 11, 6, 8, 5, 3, 15, 13, 0, 14, 9,
          14, 11, 2, 12, 4, 7, 13, 1, 5, 0, 15, 10, 3, 9, 8, 6,
          4, 2, 1, 11, 10, 13, 7, 8, 15, 9, 12, 5, 6, 3, 0, 14,
          11, 8, 12, 7, 1, 14, 2, 13, 6, 15, 0, 9, 10, 4, 5, 3},
        '{12, 1, 10, 15, 9, 2, 6, 8, 0, 13, 3, 4, 14, 7, 5, 11,
          10, 15, 4, 2, 7, 12, 9, 5, 6, 1, 13, 14, 0, 11, 3, 8,
          9, 14, 15, 5, 2, 8, 12, 3, 7, 0, 4, 10, 1, 13, 11, 6,
          4, 3, 2, 12, 9, 5, 15, 10, 11, 14, 1, 7, 6, 0, 8, 13},
        '{4, 11, 2, 14, 15, 0, 8, 13, 3, 12, 9, 7, 5, 10, 6, 1,
          13, 0, 11, 7, 4, 9, 1, 10, 14, 3, 5, 12, 2, 15, 8, 6,
          1, 4, 11, 13, 12, 3, 7, 14, 10, 15, 6, 8, 0, 5, 9, 2,
          6, 11, 13, 8, 1, 4, 10, 7, 9, 5, 0, 15, 14, 2, 3, 12},
        '{13, 2, 8, 4, 6, 15, 11, 1, 10, 9, 3, 14, 5, 0, 12, 7,
          1, 15, 13, 8, 10, 3, 7, 4, 12, 5, 6, 11, 0, 14, 9, 2,
          7, 11, 4, 1, 9, 12, 14, 2, 0, 6, 10, 13, 15, 3, 5, 8,
          2, 1, 14, 7, 4, 10, 8, 13, 15, 12, 9, 0, 3, 5, 6, 11}
    };

    // Tables use DES numbering: table entry n means vector bit (width - n).
    function automatic logic [63:0] ip_f(input logic [63:0] x);
        logic [63:0] y;
        y = '0;
        for (int i = 0; i < 64; i++)
            y[6'(63 - i)] = x[6'(7'd64 - IP_T[6'(i)])];
        return y;
    endfunction

    function automatic logic [63:0] fp_f(input logic [63:0] x);
        logic [63:0] y;
        y = '0;
        for (int i = 0; i < 64; i++)
            y[6'(63 - i)] = x[6'(7'd64 - FP_T[6'(i)])];
        return y;
    endfunction

    function automatic logic [55:0] pc1_f(input logic [63:0] x);
        logic [55:0] y;
        y = '0;
        for (int i = 0; i < 56; i++)
            y[6'(55 - i)] = x[6'(7'd64 - PC1_T[6'(i)])];
        return y;
    endfunction

    function automatic logic [47:0] pc2_f(input logic [55:0] x);
        logic [47:0] y;
        y = '0;
        for (int i = 0; i < 48; i++)
            y[6'(47 - i)] = x[6'(6'd56 - PC2_T[6'(i)])];
        return y;
    endfunction

    function automatic logic [31:0] f_f(input logic [31:0] r, input logic [47:0] k);
        logic [47:0] x;
        logic [31:0] s;
        logic [31:0] y;
        logic [5:0]  c;
        for (int i = 0; i < 48; i++)
            x[6'(47 - i)] = r[5'(6'd32 - E_T[6'(i)])];
        x = x ^ k;
        s = '0;
        for (int b = 0; b < 8; b++) begin
            c = x[6'(47 - 6 * b) -: 6];
            s[5'(31 - 4 * b) -: 4] = SBOX[3'(b)][{c[5], c[0], c[4:1]}];
        end
        y = '0;
        for (int i = 0; i < 32; i++)
            y[5'(31 - i)] = s[5'(6'd32 - P_T[5'(i)])];
        return y;
    endfunction

    function automatic logic [27:0] rot_f(input logic [27:0] v, input logic dec, input logic one);
        logic [27:0] y;
        case ({dec, one})
            2'b00:   y = {v[25:0], v[27:26]};
            2'b01:   y = {v[26:0], v[27]};
            2'b10:   y = {v[1:0], v[27:2]};
            default: y = {v[0], v[27:1]};
        endcase
        return y;
    endfunction

    function automatic logic [3:0] clamp_f(input logic [4:0] n);
        logic [3:0] y;
        if (n == 5'd0)
            y = 4'd0;
        else if (n > 5'd16)
            y = 4'd15;
        else
            y = 4'(n - 5'd1);
        return y;
    endfunction

    state_t      state_q;
    logic [31:0] l_q, r_q;
    logic [27:0] c_q, d_q;
    logic [4:0]  cnt_q;
    logic        dec_q;
    logic        in_ready_q;
    logic        out_valid_q;
    logic [63:0] out_text_q;
    logic        busy_q;
    logic [3:0]  round_idx_q;

    logic [31:0] l_d, r_d, t;
    logic [27:0] c_d, d_d;
    logic [4:0]  cnt_d, rnd;
    logic        one;
    logic [63:0] ip_w;
    logic [55:0] pc1_w;
    logic        accept;

    assign ip_w  = ip_f(io.in_text);
    assign pc1_w = pc1_f(io.in_key);
    assign cnt_d = cnt_q + 5'(RPC);

`ifdef DES_ABORT_EN
    assign accept = io.in_valid & ~abort;
`else
    assign accept = io.in_valid;
`endif

    // RPC rounds chained; decrypt round 1 uses the unrotated C/D.
    always_comb begin
        l_d = l_q;
        r_d = r_q;
        c_d = c_q;
        d_d = d_q;
        rnd = '0;
        one = 1'b0;
        t   = '0;
        for (int j = 0; j < RPC; j++) begin
            rnd = cnt_q + 5'(j + 1);
            one = (rnd == 5'd1) || (rnd == 5'd2) ||
                  (rnd == 5'd9) || (rnd == 5'd16);
            if (!dec_q || rnd != 5'd1) begin
                c_d = rot_f(c_d, dec_q, one);
                d_d = rot_f(d_d, dec_q, one);
            end
            t   = l_d ^ f_f(r_d, pc2_f({c_d, d_d}));
            l_d = r_d;
            r_d = t;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            l_q         <= '0;
            r_q         <= '0;
            c_q         <= '0;
            d_q         <= '0;
            cnt_q       <= '0;
            dec_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_text_q  <= '0;
            busy_q      <= 1'b0;
            round_idx_q <= '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        {l_q, r_q}  <= ip_w;
                        {c_q, d_q}  <= pc1_w;
                        dec_q       <= io.in_decrypt;
                        cnt_q       <= '0;
                        in_ready_q  <= 1'b0;
                        busy_q      <= 1'b1;
                        round_idx_q <= '0;
                        state_q     <= S_RUN;
                    end
                end
                S_RUN: begin
`ifdef DES_ABORT_EN
                    if (abort) begin
                        l_q         <= '0;
                        r_q         <= '0;
                        c_q         <= '0;
                        d_q         <= '0;
                        cnt_q       <= '0;
                        in_ready_q  <= 1'b1;
                        busy_q      <= 1'b0;
                        round_idx_q <= '0;
                        state_q     <= S_IDLE;
                    end else
`endif
                    begin
                        l_q   <= l_d;
                        r_q   <= r_d;
                        c_q   <= c_d;
                        d_q   <= d_d;
                        cnt_q <= cnt_d;
                        if (cnt_d == 5'd16) begin
                            out_text_q  <= fp_f({r_d, l_d});
                            out_valid_q <= 1'b1;
                            round_idx_q <= '0;
                            state_q     <= S_DONE;
                        end else begin
                            round_idx_q <= clamp_f(cnt_d);
                        end
                    end
                end
                S_DONE: begin
`ifdef DES_ABORT_EN
                    if (abort) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        busy_q      <= 1'b0;
                        state_q     <= S_IDLE;
                    end else
`endif
                    if (io.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        busy_q      <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign io.in_ready  = in_ready_q;
    assign io.out_valid = out_valid_q;
    assign io.out_text  = out_text_q;
    assign io.busy      = busy_q;
    assign io.round_idx = round_idx_q;

endmodule
